// File: rtl/restoring_div_param.sv
// Multi-cycle restoring divider, WIDTH-bit, busy/done handshake, divide-by-zero flag.
// Define RESTORING_DIV_SIGNED_EN to enable two's-complement (truncating) division.
module restoring_div_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             zero_div;
    logic             last;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    assign accept   = start && (state != S_RUN);
    assign zero_div = (divisor == '0);
    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_nxt = zero_div ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Extra top bit keeps the borrow exact even when the shifted A exceeds WIDTH bits.
    always_comb begin
        a_sh   = {a_q, q_q[WIDTH-1]};
        diff   = {1'b0, a_sh} - {2'b00, m_q};
        borrow = diff[WIDTH+1];
        a_nxt  = borrow ? a_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        q_nxt  = {q_q[WIDTH-2:0], ~borrow};
    end

`ifdef RESTORING_DIV_SIGNED_EN
    logic sgn_a_q;
    logic sgn_b_q;
    logic sgn_a;
    logic sgn_b;

    assign sgn_a = signed_mode & dividend[WIDTH-1];
    assign sgn_b = signed_mode & divisor[WIDTH-1];
    assign mag_a = sgn_a ? (~dividend + 1'b1) : dividend;
    assign mag_b = sgn_b ? (~divisor + 1'b1) : divisor;
    assign q_fin = (sgn_a_q ^ sgn_b_q) ? (~q_nxt + 1'b1) : q_nxt;
    assign r_fin = sgn_a_q ? (~a_nxt + 1'b1) : a_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
        end else if (accept) begin
            sgn_a_q <= sgn_a;
            sgn_b_q <= sgn_b;
        end
    end
`else
    logic unused_signed_mode;

    assign unused_signed_mode = signed_mode;
    assign mag_a = dividend;
    assign mag_b = divisor;
    assign q_fin = q_nxt;
    assign r_fin = a_nxt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            a_q         <= '0;
            q_q         <= mag_a;
            m_q         <= mag_b;
            cnt         <= '0;
            div_by_zero <= zero_div;
            if (zero_div) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == S_RUN) begin
            a_q <= a_nxt;
            q_q <= q_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                quotient  <= q_fin;
                remainder <= r_fin;
            end
        end
    end

endmodule

// File: tb/tb_restoring_div_param.sv
// Scoreboard bench for restoring_div_param: WIDTH=8 and WIDTH=16 instances.
// Monitors pop expected results on done and check values, latency and busy length.
module tb_restoring_div_param;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          iss;
        int          lat;
        int          bsy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t q8[$];
    exp_t q16[$];
    int   b8 = 0;
    int   b16 = 0;

    logic        s8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, d8 = '0;
    logic [7:0]  quo8, rem8;
    logic        busy8, done8, dbz8;

    logic        s16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, d16 = '0;
    logic [15:0] quo16, rem16;
    logic        busy16, done16, dbz16;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    restoring_div_param #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst_n), .start(s8), .signed_mode(sm8),
        .dividend(a8), .divisor(d8), .quotient(quo8), .remainder(rem8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8)
    );

    restoring_div_param #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst_n), .start(s16), .signed_mode(sm16),
        .dividend(a16), .divisor(d16), .quotient(quo16), .remainder(rem16),
        .busy(busy16), .done(done16), .div_by_zero(dbz16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Monitor for the 8-bit divider.
    always @(negedge clk) begin
        if (!rst_n) begin
            b8 = 0;
        end else begin
            if (busy8) b8++;
            if (done8) begin
                if (q8.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL w8_unexpected_done: q=0x%0h r=0x%0h", quo8, rem8);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("w8_quotient", {24'd0, quo8}, e.q);
                    chk("w8_remainder", {24'd0, rem8}, e.r);
                    chk("w8_div_by_zero", {31'd0, dbz8}, {31'd0, e.dbz});
                    chk("w8_latency", cyc - e.iss, e.lat);
                    chk("w8_busy_cycles", b8, e.bsy);
                end
                b8 = 0;
            end
        end
    end

    // Monitor for the 16-bit divider.
    always @(negedge clk) begin
        if (!rst_n) begin
            b16 = 0;
        end else begin
            if (busy16) b16++;
            if (done16) begin
                if (q16.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL w16_unexpected_done: q=0x%0h r=0x%0h", quo16, rem16);
                end else begin
                    exp_t e;
                    e = q16.pop_front();
                    chk("w16_quotient", {16'd0, quo16}, e.q);
                    chk("w16_remainder", {16'd0, rem16}, e.r);
                    chk("w16_div_by_zero", {31'd0, dbz16}, {31'd0, e.dbz});
                    chk("w16_latency", cyc - e.iss, e.lat);
                    chk("w16_busy_cycles", b16, e.bsy);
                end
                b16 = 0;
            end
        end
    end

    // Call at a negedge; start is seen on the following posedge.
    task automatic go8(input logic [7:0] a, input logic [7:0] d, input logic sm,
                       input logic push, input logic [7:0] eq, input logic [7:0] er,
                       input logic edz, input int lat, input int bsy);
        exp_t e;
        a8 = a;
        d8 = d;
        sm8 = sm;
        s8 = 1'b1;
        if (push) begin
            e.q = {24'd0, eq};
            e.r = {24'd0, er};
            e.dbz = edz;
            e.iss = cyc;
            e.lat = lat;
            e.bsy = bsy;
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        s8 = 1'b0;
        a8 = $urandom_range(0, 255);
        d8 = $urandom_range(0, 255);
        @(negedge clk);
    endtask

    task automatic drain;
        for (int i = 0; i < 200 && (q8.size() != 0 || q16.size() != 0); i++) begin
            @(negedge clk);
        end
        if (q8.size() != 0 || q16.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: pending8=%0d pending16=%0d", q8.size(), q16.size());
            q8.delete();
            q16.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_zero8(input string name);
        chk({name, "_q"}, {24'd0, quo8}, 32'd0);
        chk({name, "_r"}, {24'd0, rem8}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy8}, 32'd0);
        chk({name, "_done"}, {31'd0, done8}, 32'd0);
        chk({name, "_dbz"}, {31'd0, dbz8}, 32'd0);
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        chk_zero8("reset_w8");
        chk("reset_w16_q", {16'd0, quo16}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        go8(8'd100, 8'd7, 1'b0, 1'b1, 8'd14, 8'd2, 1'b0, 9, 8);
        drain();
        go8(8'd55, 8'd0, 1'b0, 1'b1, 8'hFF, 8'd55, 1'b1, 1, 0);
        drain();
        go8(8'd7, 8'd100, 1'b0, 1'b1, 8'd0, 8'd7, 1'b0, 9, 8);
        drain();
        go8(8'd255, 8'd1, 1'b0, 1'b1, 8'd255, 8'd0, 1'b0, 9, 8);
        drain();
        go8(8'd255, 8'd255, 1'b0, 1'b1, 8'd1, 8'd0, 1'b0, 9, 8);
        drain();

`ifdef RESTORING_DIV_SIGNED_EN
        go8(8'h9C, 8'd7, 1'b1, 1'b1, 8'hF2, 8'hFE, 1'b0, 9, 8);
        drain();
        go8(8'h80, 8'hFF, 1'b1, 1'b1, 8'h80, 8'h00, 1'b0, 9, 8);
        drain();
        go8(8'd100, 8'hF9, 1'b1, 1'b1, 8'hF2, 8'd2, 1'b0, 9, 8);
        drain();
`else
        go8(8'h9C, 8'd7, 1'b1, 1'b1, 8'd22, 8'd2, 1'b0, 9, 8);
        drain();
`endif

        // Start while busy is ignored; a start in the DONE cycle is accepted.
        go8(8'd200, 8'd9, 1'b0, 1'b1, 8'd22, 8'd2, 1'b0, 9, 8);
        @(negedge clk);
        @(negedge clk);
        a8 = 8'd10;
        d8 = 8'd3;
        s8 = 1'b1;
        @(posedge clk);
        #1;
        s8 = 1'b0;
        a8 = 8'd0;
        d8 = 8'd0;
        for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
        e.q = 32'd3;
        e.r = 32'd1;
        e.dbz = 1'b0;
        e.iss = cyc;
        e.lat = 9;
        e.bsy = 8;
        q8.push_back(e);
        a8 = 8'd10;
        d8 = 8'd3;
        s8 = 1'b1;
        @(posedge clk);
        #1;
        s8 = 1'b0;
        a8 = 8'd0;
        drain();

        // Asynchronous reset mid-operation.
        go8(8'd200, 8'd9, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero8("midop_reset");
        @(negedge clk);
        @(negedge clk);
        chk_zero8("held_reset");
        rst_n = 1'b1;
        @(negedge clk);
        go8(8'd100, 8'd7, 1'b0, 1'b1, 8'd14, 8'd2, 1'b0, 9, 8);
        drain();

        // 16-bit instance.
        a16 = 16'hFFFF;
        d16 = 16'd255;
        s16 = 1'b1;
        e.q = 32'd257;
        e.r = 32'd0;
        e.dbz = 1'b0;
        e.iss = cyc;
        e.lat = 17;
        e.bsy = 16;
        q16.push_back(e);
        @(posedge clk);
        #1;
        s16 = 1'b0;
        a16 = 16'd0;
        d16 = 16'd0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
